decade_chain_ctrl: RTL and testbench

//  Run/pause/clear sequencer for a cascade of NDIG decimal (BCD) counter digits.

---
 rtl/decade_pkg.sv | 24 ++
 rtl/bcd_digit.sv | 43 ++++
 rtl/decade_chain_ctrl.sv | 130 +++++++++++++
 tb/tb_decade_chain_ctrl.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/decade_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | decade_pkg : shared types and helpers for the BCD decade chain           |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package decade_pkg;

   typedef logic [3:0] bcd_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam bcd_t BCD_MAX = 4'd9;

   function automatic logic bcd_valid(input bcd_t nibble);
      return (nibble <= BCD_MAX);
   endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_digit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | bcd_digit : one 0..9 decade counter stage with cascade enable out        |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module bcd_digit
   import decade_pkg::*;
(
   input  logic clk,
   input  logic r,
   input  logic ce,
   input  logic clr,
   output bcd_t q,
   output logic tc,
   output logic ceo
);

   bcd_t q_q;
   bcd_t q_d;

   always_comb begin
      q_d = q_q;
      if (clr) begin
         q_d = 4'd0;
      end else if (ce) begin
         q_d = tc ? 4'd0 : q_q + 4'd1;
      end
   end

   always_ff @(posedge clk or posedge r) begin
      if (r) begin
         q_q <= 4'd0;
      end else begin
         q_q <= q_d;
      end
   end

   assign q   = q_q;
   assign tc  = (q_q == BCD_MAX);
   assign ceo = ce & tc;

endmodule
`default_nettype wire

// File: rtl/decade_chain_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | decade_chain_ctrl : run/pause/clear sequencer for a BCD counter chain    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module decade_chain_ctrl
   import decade_pkg::*;
#(
   parameter int NDIG = 4,
   parameter int DIV  = 50
) (
   input  logic              clk,
   input  logic              r,
   input  logic              start,
   input  logic              stop,
   input  logic              clr,
   input  logic [4*NDIG-1:0] target,
   output logic [4*NDIG-1:0] q,
   output logic              running,
   output logic              done,
   output logic              ovf,
   output logic              tco
);

   localparam int            PW       = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);

   state_t          state_q, state_d;
   logic [PW-1:0]   pre_q, pre_d;
   logic            ovf_q, ovf_d;
   logic            dig_clr;
   logic            tick;
   logic            tgt_valid;
   logic            match;
   logic [NDIG:0]   ce;
   logic [NDIG-1:0] tc;
   bcd_t            dig_q [NDIG];
   logic [4*NDIG-1:0] nxt;

   // Stop and clear both veto a tick landing on the same edge.
   assign tick  = (state_q == RUN) && (pre_q == PRE_LAST) && !clr && !stop;
   assign ce[0] = tick;

   generate
      for (genvar k = 0; k < NDIG; k++) begin : g_digit
         bcd_digit u_digit (
            .clk (clk),
            .r   (r),
            .ce  (ce[k]),
            .clr (dig_clr),
            .q   (dig_q[k]),
            .tc  (tc[k]),
            .ceo (ce[k+1])
         );
         assign q[4*k +: 4]   = dig_q[k];
         assign nxt[4*k +: 4] = ce[k] ? (tc[k] ? 4'd0 : dig_q[k] + 4'd1) : dig_q[k];
      end
   endgenerate

   always_comb begin
      tgt_valid = 1'b1;
      for (int k = 0; k < NDIG; k++) begin
         if (!bcd_valid(target[4*k +: 4])) tgt_valid = 1'b0;
      end
   end

   assign match = tick && tgt_valid && (nxt == target);
   // The cascade-out of the last stage is exactly "tick while all digits are 9".
   assign tco   = ce[NDIG];

   always_comb begin
      state_d = state_q;
      pre_d   = pre_q;
      ovf_d   = ovf_q;
      dig_clr = 1'b0;
      if (clr) begin
         state_d = IDLE;
         pre_d   = '0;
         ovf_d   = 1'b0;
         dig_clr = 1'b1;
      end else begin
         if (tco) ovf_d = 1'b1;
         case (state_q)
            IDLE: begin
               if (!stop && start) begin
                  state_d = RUN;
                  pre_d   = '0;
               end
            end
            RUN: begin
               if (stop) begin
                  state_d = PAUSE;
               end else begin
                  pre_d = (pre_q == PRE_LAST) ? '0 : pre_q + PW'(1);
                  if (match) state_d = DONE;
               end
            end
            PAUSE: begin
               if (!stop && start) state_d = RUN;
            end
            DONE: begin
               if (!stop && start) begin
                  state_d = RUN;
                  pre_d   = '0;
                  dig_clr = 1'b1;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge r) begin
      if (r) begin
         state_q <= IDLE;
         pre_q   <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         pre_q   <= pre_d;
         ovf_q   <= ovf_d;
      end
   end

   assign running = (state_q == RUN);
   assign done    = (state_q == DONE);
   assign ovf     = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_decade_chain_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_decade_chain_ctrl : directed self-checking bench, NDIG=2, DIV=2       |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_decade_chain_ctrl;

   logic       clk = 1'b0;
   logic       r = 1'b0;
   logic       start = 1'b0;
   logic       stop = 1'b0;
   logic       clr = 1'b0;
   logic [7:0] target = 8'hFF;
   logic [7:0] q;
   logic       running, done, ovf, tco;

   int vectors = 0;
   int miscompares = 0;

   always #10 clk = ~clk;

   decade_chain_ctrl #(.NDIG(2), .DIV(2)) dut (
      .clk     (clk),
      .r       (r),
      .start   (start),
      .stop    (stop),
      .clr     (clr),
      .target  (target),
      .q       (q),
      .running (running),
      .done    (done),
      .ovf     (ovf),
      .tco     (tco)
   );

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      // Asynchronous reset pulse between clock edges
      #13 r = 1'b1;
      #5;
      chk("rst_q",       q,              8'h00);
      chk("rst_running", {7'd0, running}, 8'h00);
      chk("rst_done",    {7'd0, done},    8'h00);
      chk("rst_ovf",     {7'd0, ovf},     8'h00);
      chk("rst_tco",     {7'd0, tco},     8'h00);
      #5 r = 1'b0;
      cyc(1);

      // Count to target 12
      target = 8'h12;
      start  = 1'b1;
      cyc(1); start = 1'b0;
      chk("t2_run0",  {7'd0, running}, 8'h01);
      chk("t2_q0",    q,               8'h00);
      cyc(1); chk("t2_q_k1", q, 8'h00);
      cyc(1); chk("t2_q_k2", q, 8'h01);
      cyc(21);
      chk("t2_q_k23",    q,            8'h11);
      chk("t2_done_k23", {7'd0, done}, 8'h00);
      cyc(1);
      chk("t2_q_k24",    q,               8'h12);
      chk("t2_done_k24", {7'd0, done},    8'h01);
      chk("t2_run_k24",  {7'd0, running}, 8'h00);
      cyc(10);
      chk("t2_hold_q",    q,            8'h12);
      chk("t2_hold_done", {7'd0, done}, 8'h01);

      // Restart from DONE in free-run mode
      target = 8'hFF;
      start  = 1'b1;
      cyc(1); start = 1'b0;
      chk("t6_restart_q",   q,               8'h00);
      chk("t6_restart_run", {7'd0, running}, 8'h01);
      chk("t6_restart_done", {7'd0, done},   8'h00);
      cyc(19); chk("t3_q09", q, 8'h09);
      cyc(1);  chk("t3_q10", q, 8'h10);
      cyc(178);
      chk("t3_q99",     q,           8'h99);
      chk("t3_tco_pre", {7'd0, tco}, 8'h00);
      chk("t3_ovf_pre", {7'd0, ovf}, 8'h00);
      cyc(1);
      chk("t3_tco",     {7'd0, tco}, 8'h01);
      cyc(1);
      chk("t3_wrap_q",  q,           8'h00);
      chk("t3_ovf",     {7'd0, ovf}, 8'h01);
      chk("t3_tco_end", {7'd0, tco}, 8'h00);
      cyc(11);
      chk("t4_q05",      q,           8'h05);
      chk("t3_ovf_stky", {7'd0, ovf}, 8'h01);

      // Pause on a tick cycle: stop wins, prescaler phase kept
      stop = 1'b1;
      cyc(1); stop = 1'b0;
      chk("t5_tickstop_q", q,               8'h05);
      chk("t4_pause_run",  {7'd0, running}, 8'h00);
      cyc(10);
      chk("t4_pause_hold", q, 8'h05);
      start = 1'b1;
      cyc(1); start = 1'b0;
      chk("t4_resume_run", {7'd0, running}, 8'h01);
      chk("t4_resume_q",   q,               8'h05);
      cyc(1);
      chk("t4_resume_q06", q, 8'h06);

      // Priority: stop over start, clr over start
      stop = 1'b1; start = 1'b1;
      cyc(1); stop = 1'b0;
      chk("t5_stopstart_run", {7'd0, running}, 8'h00);
      chk("t5_stopstart_q",   q,               8'h06);
      clr = 1'b1;
      cyc(1); clr = 1'b0; start = 1'b0;
      chk("t5_clr_q",   q,               8'h00);
      chk("t5_clr_ovf", {7'd0, ovf},     8'h00);
      chk("t5_clr_run", {7'd0, running}, 8'h00);

      // Reset mid-run
      start = 1'b1;
      cyc(1); start = 1'b0;
      chk("t6_idle_start_run", {7'd0, running}, 8'h01);
      cyc(6);
      chk("t6_q03", q, 8'h03);
      #3 r = 1'b1;
      #2;
      chk("t6_rst_q",   q,               8'h00);
      chk("t6_rst_run", {7'd0, running}, 8'h00);
      #3 r = 1'b0;
      cyc(1);
      start = 1'b1;
      cyc(1); start = 1'b0;
      chk("t6_after_rst_q",   q,               8'h00);
      chk("t6_after_rst_run", {7'd0, running}, 8'h01);
      cyc(2);
      chk("t6_after_rst_q01", q, 8'h01);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire
